// File: rtl/arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package arb_pkg;
   localparam int DMEM_ADDR_W  = 12;
   localparam int DMEM_DATA_W  = 32;
   localparam int DEF_MAX_WAIT = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Processor port, VGA fetch port and RAM port of the data-RAM arbiter.
interface dmem_arbiter_if;
   import arb_pkg::*;

   logic                   cpu_req;
   logic                   cpu_wen;
   logic [DMEM_ADDR_W-1:0] cpu_addr;
   logic [DMEM_DATA_W-1:0] cpu_wdata;
   logic                   cpu_gnt;
   logic                   cpu_rvalid;
   logic [DMEM_DATA_W-1:0] cpu_rdata;

   logic                   vid_req;
   logic [DMEM_ADDR_W-1:0] vid_addr;
   logic                   vid_gnt;
   logic                   vid_rvalid;
   logic [DMEM_DATA_W-1:0] vid_rdata;

   logic                   ram_wen;
   logic [DMEM_ADDR_W-1:0] ram_addr;
   logic [DMEM_DATA_W-1:0] ram_wdata;
   logic [DMEM_DATA_W-1:0] ram_rdata;

   // master: requesters plus RAM instance; slave: the arbiter
   modport master (
      output cpu_req, cpu_wen, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
             ram_wen, ram_addr, ram_wdata
   );

   modport slave (
      input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
             ram_wen, ram_addr, ram_wdata
   );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter for the VGA side; at_limit forces a VGA grant.
module arb_starve_ctr #(
   parameter int MAX_WAIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);
   localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

   logic [3:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != LIMIT))
         cnt <= cnt + 4'd1;
   end

   assign at_limit = (cnt == LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the processor (priority) and the
// VGA fetcher, with a bounded wait for the VGA side.
module dmem_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic           clock,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   logic                   at_limit;
   logic                   force_vid;
   logic                   cpu_gnt;
   logic                   vid_gnt;
   logic                   ram_wen;
   logic [DMEM_ADDR_W-1:0] ram_addr;
   logic [DMEM_DATA_W-1:0] ram_wdata;
   logic [DMEM_ADDR_W-1:0] last_addr;
   owner_e                 rd_owner;
   owner_e                 rd_owner_nxt;

   // grants are qualified by reset so nothing reaches the RAM while it is low
   assign force_vid = bus.vid_req && at_limit;
   assign vid_gnt   = reset && bus.vid_req && (force_vid || !bus.cpu_req);
   assign cpu_gnt   = reset && bus.cpu_req && !force_vid;

   arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clock    (clock),
      .reset    (reset),
      .clr      (vid_gnt || !bus.vid_req),
      .inc      (bus.vid_req && !vid_gnt),
      .at_limit (at_limit)
   );

   always_comb begin
      ram_wen      = 1'b0;
      ram_addr     = last_addr;
      ram_wdata    = '0;
      rd_owner_nxt = OWN_NONE;
      if (cpu_gnt) begin
         ram_wen   = bus.cpu_wen;
         ram_addr  = bus.cpu_addr;
         ram_wdata = bus.cpu_wdata;
         if (!bus.cpu_wen)
            rd_owner_nxt = OWN_CPU;
      end else if (vid_gnt) begin
         ram_addr     = bus.vid_addr;
         rd_owner_nxt = OWN_VID;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_owner  <= OWN_NONE;
         last_addr <= '0;
      end else begin
         rd_owner  <= rd_owner_nxt;
         last_addr <= ram_addr;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.vid_gnt    = vid_gnt;
   assign bus.ram_wen    = ram_wen;
   assign bus.ram_addr   = ram_addr;
   assign bus.ram_wdata  = ram_wdata;
   assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
   assign bus.vid_rvalid = (rd_owner == OWN_VID);
   assign bus.cpu_rdata  = bus.ram_rdata;
   assign bus.vid_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first single-port RAM model.
module tb_dmem_arbiter;
   import arb_pkg::*;

   logic clock;
   logic reset;
   int   passed;
   int   total;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   logic [31:0] mem [0:4095];
   always @(posedge clock) begin
      if (bus.ram_wen) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata     <= bus.ram_wdata;
      end else begin
         bus.ram_rdata     <= mem[bus.ram_addr];
      end
   end

   // inputs change 1ns after the rising edge; combinational outputs checked 1ns later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [11:0] ca,
                        input logic [31:0] cd, input logic vr, input logic [11:0] va);
      bus.cpu_req   = cr;
      bus.cpu_wen   = cw;
      bus.cpu_addr  = ca;
      bus.cpu_wdata = cd;
      bus.vid_req   = vr;
      bus.vid_addr  = va;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 1'b1, 12'h000, 32'h0, 1'b1, 12'h000);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({bus.cpu_gnt, bus.vid_gnt, bus.ram_wen, bus.cpu_rvalid, bus.vid_rvalid} !== 5'b0)
            $display("FAIL reset_outputs cyc %0d: gnt c/v=%b%b wen=%b rv c/v=%b%b, required all 0",
                     i, bus.cpu_gnt, bus.vid_gnt, bus.ram_wen, bus.cpu_rvalid, bus.vid_rvalid);
         else passed++;
         total++;
         if (bus.ram_addr !== 12'h000)
            $display("FAIL reset_addr: ram_addr=%h required 000", bus.ram_addr);
         else passed++;
      end
      tick();
      reset = 1'b1;
      drive(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 12'h000);
      total++;
      if (bus.cpu_gnt !== 1'b1 || bus.vid_gnt !== 1'b0)
         $display("FAIL reset_release: cpu_gnt=%b vid_gnt=%b required 1/0", bus.cpu_gnt, bus.vid_gnt);
      else passed++;
      tick();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      tick();
   endtask

   task automatic test_write_read();
      drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 12'h000);
      total++;
      if (bus.cpu_gnt !== 1'b1 || bus.ram_wen !== 1'b1 || bus.ram_addr !== 12'h010 ||
          bus.ram_wdata !== 32'hDEADBEEF)
         $display("FAIL wr_issue: gnt=%b wen=%b addr=%h wdata=%h required 1/1/010/deadbeef",
                  bus.cpu_gnt, bus.ram_wen, bus.ram_addr, bus.ram_wdata);
      else passed++;
      tick();
      drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
      total++;
      if (bus.cpu_gnt !== 1'b1 || bus.ram_wen !== 1'b0 || bus.cpu_rvalid !== 1'b0)
         $display("FAIL rd_issue: gnt=%b wen=%b rvalid=%b required 1/0/0",
                  bus.cpu_gnt, bus.ram_wen, bus.cpu_rvalid);
      else passed++;
      tick();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      total++;
      if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.vid_rvalid !== 1'b0)
         $display("FAIL rd_return: rvalid=%b rdata=%h vid_rvalid=%b required 1/deadbeef/0",
                  bus.cpu_rvalid, bus.cpu_rdata, bus.vid_rvalid);
      else passed++;
      total++;
      if (bus.ram_addr !== 12'h010 || bus.ram_wdata !== 32'h0 || bus.ram_wen !== 1'b0)
         $display("FAIL idle_hold: addr=%h wdata=%h wen=%b required 010/0/0",
                  bus.ram_addr, bus.ram_wdata, bus.ram_wen);
      else passed++;
      tick();
   endtask

   task automatic test_vid_burst();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 12'h100 + 12'(i), 32'hA000_0000 + 32'(i), 1'b0, 12'h000);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h100 + 12'(i));
         else       drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
         if (i < 3) begin
            total++;
            if (bus.vid_gnt !== 1'b1 || bus.ram_addr !== 12'h100 + 12'(i) || bus.ram_wen !== 1'b0)
               $display("FAIL vid_gnt[%0d]: gnt=%b addr=%h wen=%b required 1/%h/0",
                        i, bus.vid_gnt, bus.ram_addr, bus.ram_wen, 12'h100 + 12'(i));
            else passed++;
         end
         if (i > 0) begin
            total++;
            if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 32'hA000_0000 + 32'(i - 1) ||
                bus.cpu_rvalid !== 1'b0)
               $display("FAIL vid_ret[%0d]: rvalid=%b rdata=%h cpu_rvalid=%b required 1/%h/0",
                        i - 1, bus.vid_rvalid, bus.vid_rdata, bus.cpu_rvalid,
                        32'hA000_0000 + 32'(i - 1));
            else passed++;
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      drive(1'b1, 1'b0, 12'h200, 32'h0, 1'b1, 12'h300);
      for (int k = 0; k < 11; k++) begin
         logic exp_vid;
         exp_vid = (k % 5 == 4);
         total++;
         if (bus.vid_gnt !== exp_vid || bus.cpu_gnt !== !exp_vid)
            $display("FAIL starve_gnt[%0d]: cpu_gnt=%b vid_gnt=%b required %b/%b",
                     k, bus.cpu_gnt, bus.vid_gnt, !exp_vid, exp_vid);
         else passed++;
         if (k > 0) begin
            total++;
            if (bus.vid_rvalid !== (k % 5 == 0) || bus.cpu_rvalid !== (k % 5 != 0))
               $display("FAIL starve_rv[%0d]: cpu_rvalid=%b vid_rvalid=%b required %b/%b",
                        k, bus.cpu_rvalid, bus.vid_rvalid, (k % 5 != 0), (k % 5 == 0));
            else passed++;
         end
         tick();
      end
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      tick();
   endtask

   task automatic test_reset_mid_read();
      drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
      total++;
      if (bus.cpu_gnt !== 1'b1)
         $display("FAIL midrst_issue: cpu_gnt=%b required 1", bus.cpu_gnt);
      else passed++;
      #5;
      reset = 1'b0;
      #1;
      total++;
      if (bus.cpu_gnt !== 1'b0)
         $display("FAIL midrst_gnt: cpu_gnt=%b required 0", bus.cpu_gnt);
      else passed++;
      tick();
      total++;
      if (bus.cpu_rvalid !== 1'b0 || bus.ram_addr !== 12'h000)
         $display("FAIL midrst_rvalid: cpu_rvalid=%b ram_addr=%h required 0/000",
                  bus.cpu_rvalid, bus.ram_addr);
      else passed++;
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (bus.cpu_rvalid !== 1'b0 || bus.vid_rvalid !== 1'b0 || bus.ram_addr !== 12'h000)
            $display("FAIL midrst_stale[%0d]: rvalid c/v=%b%b ram_addr=%h required 00/000",
                     i, bus.cpu_rvalid, bus.vid_rvalid, bus.ram_addr);
         else passed++;
      end
   endtask

   task automatic test_write_then_vid();
      drive(1'b1, 1'b1, 12'h020, 32'h5A5A5A5A, 1'b0, 12'h000);
      tick();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h020);
      total++;
      if (bus.vid_gnt !== 1'b1 || bus.ram_addr !== 12'h020)
         $display("FAIL wv_issue: vid_gnt=%b addr=%h required 1/020", bus.vid_gnt, bus.ram_addr);
      else passed++;
      tick();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      total++;
      if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 32'h5A5A5A5A)
         $display("FAIL wv_return: vid_rvalid=%b vid_rdata=%h required 1/5a5a5a5a",
                  bus.vid_rvalid, bus.vid_rdata);
      else passed++;
      tick();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_wen   = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;
      test_reset();
      test_write_read();
      test_vid_burst();
      test_starvation();
      test_reset_mid_read();
      test_write_then_vid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
